operand_issue_buffer: RTL and testbench

//  Receiving end of the forward-token links that feed an ALU unit, e.g. LogicUnit.

---
 rtl/operand_issue_buffer_pkg.sv | 25 ++
 rtl/operand_issue_buffer_if.sv | 26 ++
 rtl/operand_issue_buffer_token_fifo.sv | 59 +++++
 rtl/operand_issue_buffer.sv | 82 ++++++++
 tb/tb_operand_issue_buffer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/operand_issue_buffer_pkg.sv
// Shared token types and sizing for the operand issue buffer.
// Forward tokens carry operands; backward tokens carry nack/term/condition.
package operand_issue_buffer_pkg;

  localparam int DEPTH_OPBUF = 2;
  localparam int DATA_W      = 8;
  localparam int ID_W        = 4;

  typedef struct packed {
    logic              v;
    logic              a;
    logic              c;
    logic              r;
    logic [ID_W-1:0]   i;
    logic [DATA_W-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic v;
    logic n;
    logic t;
    logic c;
  } BTk_t;

endpackage

// File: rtl/operand_issue_buffer_if.sv
// Token links between the producers, the buffer and the ALU unit.
// slave is the buffer side, master is the producer/unit side.
interface operand_issue_buffer_if;
  import operand_issue_buffer_pkg::*;

  logic I_En;
  FTk_t I_FTkA;
  BTk_t O_BTkA;
  FTk_t I_FTkB;
  BTk_t O_BTkB;
  FTk_t O_OperandA;
  FTk_t O_OperandB;
  BTk_t I_BTk;
  logic O_Empty;

  modport slave (
    input  I_En, I_FTkA, I_FTkB, I_BTk,
    output O_BTkA, O_BTkB, O_OperandA, O_OperandB, O_Empty
  );

  modport master (
    output I_En, I_FTkA, I_FTkB, I_BTk,
    input  O_BTkA, O_BTkB, O_OperandA, O_OperandB, O_Empty
  );

endinterface

// File: rtl/operand_issue_buffer_token_fifo.sv
// DEPTH-entry forward-token FIFO with synchronous flush.
// Full/empty come from the count; pointers simply wrap.
module token_fifo
  import operand_issue_buffer_pkg::*;
#(
  parameter  int DEPTH       = DEPTH_OPBUF,
  localparam int WIDTH_DEPTH = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  FTk_t               wrTok,
  output FTk_t               rdTok,
  output logic               full,
  output logic               empty,
  output logic [WIDTH_DEPTH:0] count
);

  localparam logic [WIDTH_DEPTH:0] FULL_CNT = DEPTH[WIDTH_DEPTH:0];

  FTk_t                   mem [DEPTH];
  logic [WIDTH_DEPTH-1:0] wrPtr;
  logic [WIDTH_DEPTH-1:0] rdPtr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= wrTok;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdTok = mem[rdPtr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);
  assert property (@(posedge clk) disable iff (rst) !(push && full));
  assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/operand_issue_buffer.sv
// Pairs operand A/B tokens from two producers and issues them together.
// Term from the unit flushes both FIFOs and is echoed to both producers.
module operand_issue_buffer
  import operand_issue_buffer_pkg::*;
#(
  parameter  int DEPTH       = DEPTH_OPBUF,
  localparam int WIDTH_DEPTH = $clog2(DEPTH)
) (
  input logic                   clock,
  input logic                   reset,
  operand_issue_buffer_if.slave bus
);

  FTk_t                 headA;
  FTk_t                 headB;
  logic                 fullA;
  logic                 fullB;
  logic                 emptyA;
  logic                 emptyB;
  logic [WIDTH_DEPTH:0] cntA;
  logic [WIDTH_DEPTH:0] cntB;
  logic                 nackA;
  logic                 nackB;
  logic                 pushA;
  logic                 pushB;
  logic                 issue;
  logic                 pop;
  logic                 term;

  assign term  = bus.I_BTk.t;
  assign nackA = fullA | term;
  assign nackB = fullB | term;
  assign pushA = bus.I_FTkA.v & ~nackA;
  assign pushB = bus.I_FTkB.v & ~nackB;
  assign issue = ~emptyA & ~emptyB & bus.I_En;
  // Term beats a pop so the flush sees a stable pair of FIFOs
  assign pop   = issue & ~bus.I_BTk.n & ~term;

  token_fifo #(.DEPTH(DEPTH)) fifoA (
    .clk   (clock),
    .rst   (reset),
    .push  (pushA),
    .pop   (pop),
    .flush (term),
    .wrTok (bus.I_FTkA),
    .rdTok (headA),
    .full  (fullA),
    .empty (emptyA),
    .count (cntA)
  );

  token_fifo #(.DEPTH(DEPTH)) fifoB (
    .clk   (clock),
    .rst   (reset),
    .push  (pushB),
    .pop   (pop),
    .flush (term),
    .wrTok (bus.I_FTkB),
    .rdTok (headB),
    .full  (fullB),
    .empty (emptyB),
    .count (cntB)
  );

  always_comb begin
    bus.O_OperandA   = headA;
    bus.O_OperandA.v = issue;
    bus.O_OperandB   = headB;
    bus.O_OperandB.v = issue;
    bus.O_BTkA       = '0;
    bus.O_BTkA.v     = bus.I_BTk.v;
    bus.O_BTkA.c     = bus.I_BTk.c;
    bus.O_BTkA.n     = nackA;
    bus.O_BTkA.t     = term;
    bus.O_BTkB       = '0;
    bus.O_BTkB.n     = nackB;
    bus.O_BTkB.t     = term;
  end

  assign bus.O_Empty = (cntA == '0) & (cntB == '0);

endmodule

// File: tb/tb_operand_issue_buffer.sv
// Scoreboard bench for operand_issue_buffer with a queue-based reference model.
// Driver updates the model and queues expected pairs; a monitor checks pops.
module tb_operand_issue_buffer;
  import operand_issue_buffer_pkg::*;

  localparam int DEPTH = DEPTH_OPBUF;

  typedef struct packed {
    FTk_t a;
    FTk_t b;
  } pair_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  FTk_t  qa[$];
  FTk_t  qb[$];
  pair_t expQ[$];

  always #5 clk = ~clk;

  operand_issue_buffer_if bus();

  operand_issue_buffer dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic FTk_t mkTok(logic v, logic [DATA_W-1:0] d);
    logic [31:0] r;
    FTk_t tk;
    r    = $urandom;
    tk   = r[$bits(FTk_t)-1:0];
    tk.v = v;
    tk.d = d;
    return tk;
  endfunction

  task automatic idleInputs();
    bus.I_En   = 1'b0;
    bus.I_FTkA = '0;
    bus.I_FTkB = '0;
    bus.I_BTk  = '0;
  endtask

  task automatic cycle(bit vA, bit vB, bit en, bit n, bit t,
                       logic [DATA_W-1:0] dA, logic [DATA_W-1:0] dB);
    bit   bv;
    bit   bc;
    bit   expNA;
    bit   expNB;
    bit   expIss;
    bit   doPop;
    FTk_t tkA;
    FTk_t tkB;
    FTk_t e;
    pair_t p;
    @(negedge clk);
    bv         = 1'($urandom);
    bc         = 1'($urandom);
    tkA        = mkTok(vA, dA);
    tkB        = mkTok(vB, dB);
    bus.I_FTkA = tkA;
    bus.I_FTkB = tkB;
    bus.I_En   = en;
    bus.I_BTk  = '{v: bv, n: n, t: t, c: bc};
    #1;
    expNA  = (qa.size() == DEPTH) || t;
    expNB  = (qb.size() == DEPTH) || t;
    expIss = (qa.size() > 0) && (qb.size() > 0) && en;
    chk("nackA", bus.O_BTkA.n, expNA);
    chk("nackB", bus.O_BTkB.n, expNB);
    chk("issueA", bus.O_OperandA.v, expIss);
    chk("issueB", bus.O_OperandB.v, expIss);
    if (qa.size() > 0) begin
      e = qa[0];
      e.v = expIss;
      chk("headA", bus.O_OperandA, e);
    end
    if (qb.size() > 0) begin
      e = qb[0];
      e.v = expIss;
      chk("headB", bus.O_OperandB, e);
    end
    chk("termA", bus.O_BTkA.t, t);
    chk("termB", bus.O_BTkB.t, t);
    chk("condA", {bus.O_BTkA.v, bus.O_BTkA.c}, {bv, bc});
    chk("condB", {bus.O_BTkB.v, bus.O_BTkB.c}, 2'b00);
    chk("empty", bus.O_Empty, (qa.size() == 0) && (qb.size() == 0));
    doPop = expIss && !n && !t;
    if (t) begin
      qa.delete();
      qb.delete();
    end else begin
      if (doPop) begin
        p.a = qa.pop_front();
        p.b = qb.pop_front();
        p.a.v = 1'b1;
        p.b.v = 1'b1;
        expQ.push_back(p);
      end
      if (vA && !expNA) qa.push_back(tkA);
      if (vB && !expNB) qb.push_back(tkB);
    end
  endtask

  // Monitor: every pair the unit accepts must match the next expected pair
  initial begin
    pair_t p;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.O_OperandA.v && !bus.I_BTk.n && !bus.I_BTk.t) begin
        if (expQ.size() == 0) begin
          chk("unexpectedPop", expQ.size(), 1);
        end else begin
          p = expQ.pop_front();
          chk("pairA", bus.O_OperandA, p.a);
          chk("pairB", bus.O_OperandB, p.b);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rstOpA", bus.O_OperandA, 0);
    chk("rstOpB", bus.O_OperandB, 0);
    chk("rstBTkA", bus.O_BTkA, 0);
    chk("rstBTkB", bus.O_BTkB, 0);
    chk("rstEmpty", bus.O_Empty, 1);
    @(negedge clk);
    rst = 1'b0;

    // basic pair with one-cycle latency
    cycle(1, 1, 1, 0, 0, 8'h5, 8'h3);
    cycle(0, 0, 1, 0, 0, 8'h0, 8'h0);
    cycle(0, 0, 1, 0, 0, 8'h0, 8'h0);

    // A fills while B idles, then B releases one pair
    cycle(1, 0, 1, 0, 0, 8'h1, 8'h0);
    cycle(1, 0, 1, 0, 0, 8'h2, 8'h0);
    cycle(1, 0, 1, 0, 0, 8'h7, 8'h0);
    cycle(0, 1, 1, 0, 0, 8'h0, 8'h9);
    cycle(0, 0, 1, 0, 0, 8'h0, 8'h0);
    cycle(0, 1, 1, 0, 0, 8'h0, 8'hA);
    repeat (2) cycle(0, 0, 1, 0, 0, 8'h0, 8'h0);

    // both full, unit stalls, then drains
    repeat (2) cycle(1, 1, 0, 0, 0, 8'($urandom), 8'($urandom));
    repeat (3) cycle(0, 0, 1, 1, 0, 8'h0, 8'h0);
    repeat (3) cycle(0, 0, 1, 0, 0, 8'h0, 8'h0);

    // streaming, several pointer wraps
    repeat (14) cycle(1, 1, 1, 0, 0, 8'($urandom), 8'($urandom));
    repeat (2) cycle(0, 0, 1, 0, 0, 8'h0, 8'h0);

    // term with A=1, B=2 and a concurrent push on A
    cycle(1, 1, 0, 0, 0, 8'h11, 8'h21);
    cycle(0, 1, 0, 0, 0, 8'h0, 8'h22);
    cycle(1, 0, 0, 0, 1, 8'h33, 8'h0);
    cycle(0, 0, 1, 0, 0, 8'h0, 8'h0);

    // random traffic
    repeat (300)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, 8'($urandom), 8'($urandom));

    // load up, then asynchronous reset between edges
    repeat (2) cycle(1, 1, 0, 0, 0, 8'($urandom), 8'($urandom));
    @(negedge clk);
    idleInputs();
    #2;
    rst = 1'b1;
    #1;
    chk("arstOpA", bus.O_OperandA, 0);
    chk("arstOpB", bus.O_OperandB, 0);
    chk("arstBTkA", bus.O_BTkA, 0);
    chk("arstEmpty", bus.O_Empty, 1);
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) cycle(1, 1, 1, 0, 0, 8'($urandom), 8'($urandom));
    repeat (3) cycle(0, 0, 1, 0, 0, 8'h0, 8'h0);

    @(negedge clk);
    #3;
    chk("drain", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
